// File: rtl/song_sequencer.sv
// Song sequencer: steps through a small writable table of (period, duration)
// entries and drives a note player, one note at a time, timed by tick strobes.
module song_sequencer #(
    parameter int unsigned PERIOD_W = 8,
    parameter int unsigned DUR_W    = 12,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [PERIOD_W-1:0] i_wr_period,
    input  logic [DUR_W-1:0]    i_wr_dur,
    input  logic [ADDR_W:0]     i_song_len,
    input  logic                i_loop,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_tick,
    output logic [PERIOD_W-1:0] o_note_period,
    output logic                o_note_en,
    output logic                o_note_new,
    output logic [ADDR_W-1:0]   o_cur_addr,
    output logic                o_busy,
    output logic                o_done
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StPlay, StNext} state_e;

    state_e              r_state, w_state_nxt;
    logic [PERIOD_W-1:0] r_tbl_period [DEPTH];
    logic [DUR_W-1:0]    r_tbl_dur    [DEPTH];
    logic [ADDR_W-1:0]   r_cur_addr, w_addr_nxt;
    logic [PERIOD_W-1:0] r_note_period, w_period_nxt;
    logic [DUR_W-1:0]    r_dur_cnt, w_dur_nxt;
    logic                r_note_new, w_new_nxt;
    logic                r_done, w_done_nxt;
    logic [ADDR_W:0]     w_len;
    logic [ADDR_W:0]     w_addr_inc;
    logic [PERIOD_W-1:0] w_tbl_period;
    logic [DUR_W-1:0]    w_tbl_dur;

    // Oversized song lengths are clamped to the table depth.
    assign w_len        = (i_song_len > LEN_MAX) ? LEN_MAX : i_song_len;
    assign w_addr_inc   = {1'b0, r_cur_addr} + (ADDR_W+1)'(1);
    assign w_tbl_period = r_tbl_period[r_cur_addr];
    assign w_tbl_dur    = r_tbl_dur[r_cur_addr];

    // Song table write port; contents survive reset on purpose.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tbl_period[i_wr_addr] <= i_wr_period;
            r_tbl_dur[i_wr_addr]    <= i_wr_dur;
        end
    end

    // State and captured-note registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_cur_addr    <= '0;
            r_note_period <= '0;
            r_dur_cnt     <= '0;
            r_note_new    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cur_addr    <= w_addr_nxt;
            r_note_period <= w_period_nxt;
            r_dur_cnt     <= w_dur_nxt;
            r_note_new    <= w_new_nxt;
            r_done        <= w_done_nxt;
        end
    end

    // Next-state logic; stop overrides everything outside IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_cur_addr;
        w_period_nxt = r_note_period;
        w_dur_nxt    = r_dur_cnt;
        w_new_nxt    = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start && !i_stop) begin
                    if (w_len != '0) begin
                        w_state_nxt = StFetch;
                        w_addr_nxt  = '0;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            StFetch: begin
                if (i_stop) begin
                    w_state_nxt = StIdle;
                end else begin
                    // Capture here so later table writes cannot disturb this note.
                    w_period_nxt = w_tbl_period;
                    w_dur_nxt    = w_tbl_dur;
                    if (w_tbl_dur == '0) begin
                        w_state_nxt = StNext;
                    end else begin
                        w_state_nxt = StPlay;
                        w_new_nxt   = 1'b1;
                    end
                end
            end
            StPlay: begin
                if (i_stop) begin
                    w_state_nxt = StIdle;
                end else if (i_tick) begin
                    if (r_dur_cnt <= DUR_W'(1)) begin
                        w_state_nxt = StNext;
                    end else begin
                        w_dur_nxt = r_dur_cnt - DUR_W'(1);
                    end
                end
            end
            StNext: begin
                if (i_stop) begin
                    w_state_nxt = StIdle;
                end else if (w_addr_inc >= w_len) begin
                    // >= so a song_len shrunk mid-play still ends cleanly.
                    if (i_loop) begin
                        w_state_nxt = StFetch;
                        w_addr_nxt  = '0;
                    end else begin
                        w_state_nxt = StIdle;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = StFetch;
                    w_addr_nxt  = w_addr_inc[ADDR_W-1:0];
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign o_note_period = r_note_period;
    assign o_note_en     = (r_state == StPlay) && (r_note_period != '0);
    assign o_note_new    = r_note_new;
    assign o_cur_addr    = r_cur_addr;
    assign o_busy        = (r_state != StIdle);
    assign o_done        = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a per-cycle vector table for a full
// two-entry song, plus hand-written sequences for loop, stop, skip, reset and
// table-rewrite corner cases.
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_period;
    logic [11:0] wr_dur;
    logic [4:0]  song_len;
    logic        loop_i;
    logic        start;
    logic        stop;
    logic        tick;
    logic [7:0]  note_period;
    logic        note_en;
    logic        note_new;
    logic [3:0]  cur_addr;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        start;
        logic        stop;
        logic        tick;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    song_sequencer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_period  (wr_period),
        .i_wr_dur     (wr_dur),
        .i_song_len   (song_len),
        .i_loop       (loop_i),
        .i_start      (start),
        .i_stop       (stop),
        .i_tick       (tick),
        .o_note_period(note_period),
        .o_note_en    (note_en),
        .o_note_new   (note_new),
        .o_cur_addr   (cur_addr),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // {period, en, new, addr, busy, done}
    function automatic logic [15:0] pk(input logic [7:0] p, input logic en, input logic nw,
                                       input logic [3:0] a, input logic b, input logic d);
        return {p, en, nw, a, b, d};
    endfunction

    task automatic chk(input string name, input logic [15:0] exp);
        logic [15:0] got;
        got = pk(note_period, note_en, note_new, cur_addr, busy, done);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {per,en,new,addr,busy,done}=%h required %h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Apply current inputs across one rising edge; return at the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [7:0] p, input logic [11:0] d);
        wr_en = 1'b1; wr_addr = a; wr_period = p; wr_dur = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic add(input logic s, input logic sp, input logic t, input logic [15:0] e);
        vec_t v;
        v.start = s; v.stop = sp; v.tick = t; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        int new_cnt;
        int done_seen;
        int idle_seen;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;
        song_len = '0; loop_i = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        cyc();
        cyc();
        chk("reset_state", pk(8'd0, 0, 0, 4'd0, 0, 0));
        rst_n = 1'b1;
        cyc();

        // Two-entry song, no loop, tick every 4 cycles.
        write_entry(4'd0, 8'd50, 12'd3);
        write_entry(4'd1, 8'd0, 12'd2);
        song_len = 5'd2;
        add(1, 0, 0, pk(8'd0,  0, 0, 4'd0, 1, 0)); // FETCH 0
        add(0, 0, 0, pk(8'd50, 1, 1, 4'd0, 1, 0)); // PLAY, note_new
        add(0, 0, 0, pk(8'd50, 1, 0, 4'd0, 1, 0));
        add(0, 0, 1, pk(8'd50, 1, 0, 4'd0, 1, 0)); // tick 1
        add(0, 0, 0, pk(8'd50, 1, 0, 4'd0, 1, 0));
        add(0, 0, 0, pk(8'd50, 1, 0, 4'd0, 1, 0));
        add(0, 0, 0, pk(8'd50, 1, 0, 4'd0, 1, 0));
        add(0, 0, 1, pk(8'd50, 1, 0, 4'd0, 1, 0)); // tick 2
        add(0, 0, 0, pk(8'd50, 1, 0, 4'd0, 1, 0));
        add(0, 0, 0, pk(8'd50, 1, 0, 4'd0, 1, 0));
        add(0, 0, 0, pk(8'd50, 1, 0, 4'd0, 1, 0));
        add(0, 0, 1, pk(8'd50, 0, 0, 4'd0, 1, 0)); // tick 3 -> NEXT
        add(0, 0, 0, pk(8'd50, 0, 0, 4'd1, 1, 0)); // FETCH 1
        add(0, 0, 0, pk(8'd0,  0, 1, 4'd1, 1, 0)); // PLAY rest
        add(0, 0, 0, pk(8'd0,  0, 0, 4'd1, 1, 0));
        add(0, 0, 1, pk(8'd0,  0, 0, 4'd1, 1, 0)); // tick 1
        add(0, 0, 0, pk(8'd0,  0, 0, 4'd1, 1, 0));
        add(0, 0, 0, pk(8'd0,  0, 0, 4'd1, 1, 0));
        add(0, 0, 0, pk(8'd0,  0, 0, 4'd1, 1, 0));
        add(0, 0, 1, pk(8'd0,  0, 0, 4'd1, 1, 0)); // tick 2 -> NEXT
        add(0, 0, 0, pk(8'd0,  0, 0, 4'd1, 0, 1)); // IDLE, done
        add(0, 0, 0, pk(8'd0,  0, 0, 4'd1, 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; stop = vecs[i].stop; tick = vecs[i].tick;
            cyc();
            chk($sformatf("song_vec%0d", i), vecs[i].exp);
        end
        start = 1'b0; stop = 1'b0; tick = 1'b0;

        // Looping: entry 0 must come round again with note_new, no done.
        loop_i = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        tick = 1'b1;
        new_cnt = 0; done_seen = 0; idle_seen = 0;
        for (int i = 0; i < 40 && new_cnt < 2; i++) begin
            cyc();
            if (note_new && cur_addr == 4'd0 && note_period == 8'd50) new_cnt++;
            if (done) done_seen++;
            if (!busy) idle_seen++;
        end
        chk_int("loop_new_pulses", new_cnt, 2);
        chk_int("loop_no_done", done_seen, 0);
        chk_int("loop_busy_held", idle_seen, 0);
        tick = 1'b0; stop = 1'b1;
        cyc();
        stop = 1'b0; loop_i = 1'b0;
        chk("loop_stop", pk(8'd50, 0, 0, 4'd0, 0, 0));

        // Stop on the 2nd tick of a 5-tick note; start while busy is ignored.
        write_entry(4'd0, 8'd100, 12'd5);
        song_len = 5'd1;
        start = 1'b1;
        cyc();
        chk("stop_fetch", pk(8'd50, 0, 0, 4'd0, 1, 0));
        start = 1'b0; tick = 1'b1;
        cyc();
        chk("stop_play", pk(8'd100, 1, 1, 4'd0, 1, 0));
        start = 1'b1;
        cyc();
        chk("stop_start_ignored", pk(8'd100, 1, 0, 4'd0, 1, 0));
        start = 1'b0; stop = 1'b1;
        cyc();
        chk("stop_idle", pk(8'd100, 0, 0, 4'd0, 0, 0));
        stop = 1'b0; tick = 1'b0;
        cyc();
        chk("stop_no_done", pk(8'd100, 0, 0, 4'd0, 0, 0));

        // Empty song: done pulse only.
        song_len = 5'd0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("len0_done", pk(8'd100, 0, 0, 4'd0, 0, 1));
        cyc();
        chk("len0_after", pk(8'd100, 0, 0, 4'd0, 0, 0));

        // Zero-duration entry is skipped without note_new.
        write_entry(4'd0, 8'd33, 12'd0);
        write_entry(4'd1, 8'd20, 12'd1);
        song_len = 5'd2;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("skip_fetch0", pk(8'd100, 0, 0, 4'd0, 1, 0));
        cyc();
        chk("skip_next0", pk(8'd33, 0, 0, 4'd0, 1, 0));
        cyc();
        chk("skip_fetch1", pk(8'd33, 0, 0, 4'd1, 1, 0));
        cyc();
        chk("skip_play1", pk(8'd20, 1, 1, 4'd1, 1, 0));
        cyc();
        chk("skip_hold", pk(8'd20, 1, 0, 4'd1, 1, 0));
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("skip_one_tick", pk(8'd20, 0, 0, 4'd1, 1, 0));
        cyc();
        chk("skip_done", pk(8'd20, 0, 0, 4'd1, 0, 1));

        // Asynchronous reset while a note is sounding.
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("rst_pre_play", pk(8'd20, 1, 1, 4'd1, 1, 0));
        #2 rst_n = 1'b0;
        #1 chk("rst_async", pk(8'd0, 0, 0, 4'd0, 0, 0));
        #1 rst_n = 1'b1;
        cyc();
        chk("rst_after", pk(8'd0, 0, 0, 4'd0, 0, 0));

        // Rewriting the playing entry only affects the next loop pass.
        write_entry(4'd0, 8'd50, 12'd2);
        song_len = 5'd1; loop_i = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("rw_play", pk(8'd50, 1, 1, 4'd0, 1, 0));
        wr_en = 1'b1; wr_addr = 4'd0; wr_period = 8'd77; wr_dur = 12'd2;
        cyc();
        wr_en = 1'b0;
        chk("rw_unchanged", pk(8'd50, 1, 0, 4'd0, 1, 0));
        tick = 1'b1;
        cyc();
        cyc();
        tick = 1'b0;
        chk("rw_next", pk(8'd50, 0, 0, 4'd0, 1, 0));
        cyc();
        chk("rw_fetch", pk(8'd50, 0, 0, 4'd0, 1, 0));
        cyc();
        chk("rw_new_value", pk(8'd77, 1, 1, 4'd0, 1, 0));
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("rw_stop", pk(8'd77, 0, 0, 4'd0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
